fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request FSM feeding the
// IF/ID register, with a one-entry skid buffer to absorb responses under stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_next;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pcplus4;
  logic        r_skid_vld;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_pcplus4;

  logic        w_grant;
  logic        w_resp;
  logic        w_id_free;
  logic        w_consume;
  logic [31:0] w_redirect_pc;

  // A full skid buffer blocks new requests, so the skid can never overflow.
  assign imem_req      = (r_state == S_FETCH) && !r_skid_vld && !reset;
  assign imem_addr     = r_pc;
  assign w_grant       = imem_req && imem_gnt;
  assign w_resp        = (r_state == S_WAIT) && imem_rvalid;
  assign w_id_free     = !r_id_valid || !stall;
  assign w_consume     = r_id_valid && !stall;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
    end else if (redirect) begin
      // A request already accepted for the old path must be drained.
      r_pc <= w_redirect_pc;
      case (r_state)
        S_FETCH: r_state <= w_grant ? S_DRAIN : S_FETCH;
        default: r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_grant) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state <= S_FETCH;
            r_pc    <= r_pc_next;
          end
        end
        default: begin
          if (imem_rvalid) r_state <= S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_pc_next <= r_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (w_resp) begin
      r_skid_instr   <= imem_rdata;
      r_skid_pc      <= r_pc;
      r_skid_pcplus4 <= r_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= 32'h0;
      r_id_pc      <= 32'h0;
      r_id_pcplus4 <= 32'h0;
      r_skid_vld   <= 1'b0;
    end else if (redirect) begin
      r_id_valid <= 1'b0;
      r_id_instr <= 32'h0;
      r_skid_vld <= 1'b0;
    end else if (r_skid_vld) begin
      // Skid is only ever full behind a valid, stalled IF/ID entry.
      if (!stall) begin
        r_id_valid   <= 1'b1;
        r_id_instr   <= r_skid_instr;
        r_id_pc      <= r_skid_pc;
        r_id_pcplus4 <= r_skid_pcplus4;
        r_skid_vld   <= 1'b0;
      end
    end else if (w_resp && w_id_free) begin
      r_id_valid   <= 1'b1;
      r_id_instr   <= imem_rdata;
      r_id_pc      <= r_pc;
      r_id_pcplus4 <= r_pc_next;
    end else if (w_resp) begin
      r_skid_vld <= 1'b1;
    end else if (w_consume) begin
      r_id_valid <= 1'b0;
    end
  end

  assign id_valid   = r_id_valid;
  assign id_instr   = r_id_instr;
  assign id_pc      = r_id_pc;
  assign id_pcplus4 = r_id_pcplus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed corner sequences, a redirect-alignment vector
// table and a randomized run against an in-order instruction-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;

  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        wq_req;
  logic [31:0] wq_addr;
  logic        wq_valid;
  logic [31:0] wq_instr;
  logic [31:0] wq_pc;
  logic [31:0] wq_pcp4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pcplus4(id_pcplus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(wq_req), .imem_addr(wq_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .id_valid(wq_valid), .id_instr(wq_instr), .id_pc(wq_pc), .id_pcplus4(wq_pcp4)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_p4;
  } vec_t;
  vec_t vecs [5];

  // Memory and instruction-stream model state
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_q;
  logic [31:0] exp_pc;
  bit          hold_chk;
  logic [31:0] h_instr, h_pc, h_p4;
  int          consumed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; exp_pc = 32'h0; hold_chk = 1'b0;
  endtask

  // One clock of the model-driven environment; called just after an edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic g, input int lat);
    if (hold_chk) begin
      chkb("hold_valid", id_valid, 1'b1);
      chk("hold_instr", id_instr, h_instr);
      chk("hold_pc", id_pc, h_pc);
      chk("hold_pcp4", id_pcplus4, h_p4);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_q);
      end else begin
        mem_cnt = mem_cnt - 1;
      end
    end
    stall = st; redirect = rd; redirect_pc = rpc; imem_gnt = g;
    #1;
    if (imem_req) begin
      chkb("one_outstanding", mem_busy, 1'b0);
      chk("addr_align", imem_addr & 32'h3, 32'h0);
    end
    if (id_valid && !stall && !redirect) begin
      chk("stream_pc", id_pc, exp_pc);
      chk("stream_instr", id_instr, mem_word(exp_pc));
      chk("stream_pcp4", id_pcplus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (redirect) exp_pc = rpc & 32'hFFFF_FFFC;
    hold_chk = id_valid && stall && !redirect;
    h_instr = id_instr; h_pc = id_pc; h_p4 = id_pcplus4;
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_req && imem_gnt) begin
      mem_busy = 1'b1; mem_cnt = lat; mem_addr_q = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int          rise [3];
    int          nr;
    logic        r_st, r_rd, r_g;
    logic [31:0] r_rpc;
    int          r_lat;

    vecs[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200, exp_p4: 32'h0000_0204};
    vecs[1] = '{rpc: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC, exp_p4: 32'h0000_0000};
    vecs[2] = '{rpc: 32'h0000_0007, exp_addr: 32'h0000_0004, exp_p4: 32'h0000_0008};
    vecs[3] = '{rpc: 32'h0000_1000, exp_addr: 32'h0000_1000, exp_p4: 32'h0000_1004};
    vecs[4] = '{rpc: 32'h0000_0002, exp_addr: 32'h0000_0000, exp_p4: 32'h0000_0004};
    consumed = 0;

    // Reset state and first request, plus the wrapping-PC instance
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    tick(); tick(); tick();
    chkb("rst_req", imem_req, 1'b0);
    chkb("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pcp4", id_pcplus4, 32'h0);
    chkb("rst_wrap_req", wq_req, 1'b0);
    reset = 1'b0;
    tick();
    chkb("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chkb("wrap_req0", wq_req, 1'b1);
    chk("wrap_addr0", wq_addr, 32'hFFFF_FFFC);
    w_gnt = 1'b1; tick();
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h0000_0013; tick();
    w_rvalid = 1'b0;
    chkb("wrap_valid", wq_valid, 1'b1);
    chk("wrap_instr", wq_instr, 32'h0000_0013);
    chk("wrap_pc", wq_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", wq_pcp4, 32'h0);
    chkb("wrap_req1", wq_req, 1'b1);
    chk("wrap_addr1", wq_addr, 32'h0);

    // Straight-line fetch, one idle cycle between grant and response
    do_reset();
    nr = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 2);
      if (id_valid && nr < 3) begin
        chk("straight_pc", id_pc, 4 * nr);
        chk("straight_pcp4", id_pcplus4, 4 * nr + 4);
        rise[nr] = i;
        nr++;
      end
    end
    chk("straight_count", nr, 3);
    if (nr == 3) begin
      chk("first_latency", rise[0], 2);
      chk("cadence1", rise[1] - rise[0], 3);
      chk("cadence2", rise[2] - rise[1], 3);
    end

    // Stall hold with a response landing in the skid buffer
    do_reset();
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; tick();
    imem_rvalid = 1'b0;
    chk("stall_setup_instr", id_instr, 32'h0000_0013);
    stall = 1'b1; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0040_0093; tick();
    imem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_instr", id_instr, 32'h0000_0013);
      chk("stall_pc", id_pc, 32'h0);
      chkb("stall_valid", id_valid, 1'b1);
      chkb("stall_req", imem_req, 1'b0);
      if (k < 3) tick();
    end
    stall = 1'b0; tick();
    chk("skid_instr", id_instr, 32'h0040_0093);
    chk("skid_pc", id_pc, 32'h4);
    chk("skid_pcp4", id_pcplus4, 32'h8);
    chkb("skid_valid", id_valid, 1'b1);
    tick();
    chkb("skid_drained_valid", id_valid, 1'b0);
    chkb("skid_next_req", imem_req, 1'b1);
    chk("skid_next_addr", imem_addr, 32'h8);

    // Redirect while waiting, stale response dropped
    do_reset();
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; tick();
    redirect = 1'b0;
    chkb("drain_req", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
    imem_rvalid = 1'b0;
    chkb("drain_discard_valid", id_valid, 1'b0);
    chkb("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0113; tick();
    imem_rvalid = 1'b0;
    chkb("redir_resp_valid", id_valid, 1'b1);
    chk("redir_resp_pc", id_pc, 32'h100);
    chk("redir_resp_instr", id_instr, 32'h0000_0113);

    // Redirect and stall together flush the valid entry
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h203; tick();
    stall = 1'b0; redirect = 1'b0;
    chkb("rs_valid", id_valid, 1'b0);
    chk("rs_instr", id_instr, 32'h0);
    chkb("rs_req", imem_req, 1'b1);
    chk("rs_addr", imem_addr, 32'h200);

    // Redirect target alignment and PC+4 table
    for (int v = 0; v < 5; v++) begin
      redirect = 1'b1; redirect_pc = vecs[v].rpc; tick();
      redirect = 1'b0;
      chkb("vec_req", imem_req, 1'b1);
      chk("vec_addr", imem_addr, vecs[v].exp_addr);
      imem_gnt = 1'b1; tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000 + v; tick();
      imem_rvalid = 1'b0;
      chk("vec_id_pc", id_pc, vecs[v].exp_addr);
      chk("vec_id_pcp4", id_pcplus4, vecs[v].exp_p4);
    end

    // Redirect coinciding with a grant, then a second redirect inside DRAIN
    redirect = 1'b1; redirect_pc = 32'h40; imem_gnt = 1'b1; tick();
    redirect = 1'b0; imem_gnt = 1'b0;
    chkb("rg_drain_req", imem_req, 1'b0);
    chkb("rg_valid", id_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h80; tick();
    redirect = 1'b0;
    chkb("rg_still_drain", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000; tick();
    imem_rvalid = 1'b0;
    chkb("rg_req", imem_req, 1'b1);
    chk("rg_addr", imem_addr, 32'h80);
    chkb("rg_after_valid", id_valid, 1'b0);

    // Reset during WAIT, response arrives after release
    do_reset();
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; reset = 1'b1; #1;
    chkb("rw_req_in_reset", imem_req, 1'b0);
    tick();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD; tick();
    imem_rvalid = 1'b0;
    chkb("rw_valid", id_valid, 1'b0);
    chkb("rw_req", imem_req, 1'b1);
    chk("rw_addr", imem_addr, 32'h0);
    tick();
    chkb("rw_valid_later", id_valid, 1'b0);

    // Randomized traffic against the in-order stream model
    do_reset();
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      r_st  = ($urandom_range(2) == 0);
      r_rd  = ($urandom_range(19) == 0);
      r_g   = ($urandom_range(1) == 0);
      r_rpc = $urandom;
      r_lat = int'($urandom_range(3, 1));
      step(r_st, r_rd, r_rpc, r_g, r_lat);
    end
    chkb("random_progress", consumed > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
